// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register file.
//   AXI_OK / AXI_SLVERR : response codes driven on bresp / rresp.
//   wr_state_t          : write-channel FSM encoding.
//   rd_state_t          : read-channel FSM encoding.
package axi_lite_pkg;

  localparam logic [1:0] AXI_OK     = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE,
    W_WAIT_DATA,
    W_WAIT_ADDR,
    W_COMMIT,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_lite_regfile_read_port.sv
// AXI4-Lite read channel for the register file.
// Decodes the word index into a read/write register, a status word, or an
// out-of-range hole, and returns the value with a registered response.
// Ports:
//   s_axi_lite_aclk, axi_resetn        : clock, async active-low reset
//   s_axi_lite_ar*, s_axi_lite_r*      : AXI4-Lite AR and R channels
//   reg_flat                           : flattened read/write registers
//   status_in                          : flattened read-only status words
module axi_lite_regfile_read_port
  import axi_lite_pkg::*;
#(
  parameter int AXI_LITE_ADDR_WIDTH = 8,
  parameter int REG_FILE_SIZE       = 8,
  parameter int NUM_STATUS          = 2
) (
  input  logic                           s_axi_lite_aclk,
  input  logic                           axi_resetn,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_araddr,
  input  logic                           s_axi_lite_arvalid,
  output logic                           s_axi_lite_arready,
  output logic [31:0]                    s_axi_lite_rdata,
  output logic [1:0]                     s_axi_lite_rresp,
  output logic                           s_axi_lite_rvalid,
  input  logic                           s_axi_lite_rready,
  input  logic [32*REG_FILE_SIZE-1:0]    reg_flat,
  input  logic [32*NUM_STATUS-1:0]       status_in
);

  localparam int IDX_W = AXI_LITE_ADDR_WIDTH - 2;

  rd_state_t        rd_state;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      fetch_data;
  logic [1:0]       fetch_resp;

  // Byte offset within a word carries no meaning for 32-bit registers.
  logic unused_araddr_bits;
  assign unused_araddr_bits = ^s_axi_lite_araddr[1:0];

  assign s_axi_lite_arready = (rd_state == R_IDLE);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fetch_data = '0;
    fetch_resp = AXI_SLVERR;
    for (int i = 0; i < REG_FILE_SIZE; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        fetch_data = reg_flat[32*i +: 32];
        fetch_resp = AXI_OK;
      end
    end
    for (int j = 0; j < NUM_STATUS; j++) begin
      if (rd_idx == IDX_W'(REG_FILE_SIZE + j)) begin
        fetch_data = status_in[32*j +: 32];
        fetch_resp = AXI_OK;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge s_axi_lite_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      rd_state          <= R_IDLE;
      rd_idx            <= '0;
      s_axi_lite_rdata  <= '0;
      s_axi_lite_rresp  <= AXI_OK;
      s_axi_lite_rvalid <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (s_axi_lite_arvalid) begin
            rd_idx   <= s_axi_lite_araddr[AXI_LITE_ADDR_WIDTH-1:2];
            rd_state <= R_FETCH;
          end
        end
        R_FETCH: begin
          // Samples registers before any same-edge write commit lands.
          s_axi_lite_rdata  <= fetch_data;
          s_axi_lite_rresp  <= fetch_resp;
          s_axi_lite_rvalid <= 1'b1;
          rd_state          <= R_DATA;
        end
        R_DATA: begin
          if (s_axi_lite_rready) begin
            s_axi_lite_rvalid <= 1'b0;
            rd_state          <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: REG_FILE_SIZE byte-strobed read/write
// control registers followed by NUM_STATUS read-only status words.
// Ports:
//   s_axi_lite_aclk, axi_resetn          : clock, async active-low reset
//   s_axi_lite_aw*, _w*, _b*             : AXI4-Lite write channels
//   s_axi_lite_ar*, _r*                  : AXI4-Lite read channels
//   reg_out                              : register i on bits [32i+31:32i]
//   reg_wr_pulse                         : one-cycle pulse per committed write
//   status_in                            : status word j read at REG_FILE_SIZE+j
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int          AXI_LITE_ADDR_WIDTH = 8,
  parameter int          REG_FILE_SIZE       = 8,
  parameter int          NUM_STATUS          = 2,
  parameter logic [31:0] RESET_VALUE         = 32'h0
) (
  input  logic                           s_axi_lite_aclk,
  input  logic                           axi_resetn,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_awaddr,
  input  logic                           s_axi_lite_awvalid,
  output logic                           s_axi_lite_awready,
  input  logic [31:0]                    s_axi_lite_wdata,
  input  logic [3:0]                     s_axi_lite_wstrb,
  input  logic                           s_axi_lite_wvalid,
  output logic                           s_axi_lite_wready,
  output logic [1:0]                     s_axi_lite_bresp,
  output logic                           s_axi_lite_bvalid,
  input  logic                           s_axi_lite_bready,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_araddr,
  input  logic                           s_axi_lite_arvalid,
  output logic                           s_axi_lite_arready,
  output logic [31:0]                    s_axi_lite_rdata,
  output logic [1:0]                     s_axi_lite_rresp,
  output logic                           s_axi_lite_rvalid,
  input  logic                           s_axi_lite_rready,
  output logic [32*REG_FILE_SIZE-1:0]    reg_out,
  output logic [REG_FILE_SIZE-1:0]       reg_wr_pulse,
  input  logic [32*NUM_STATUS-1:0]       status_in
);

  localparam int IDX_W = AXI_LITE_ADDR_WIDTH - 2;

  wr_state_t        wr_state;
  logic [IDX_W-1:0] aw_idx;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic [31:0]      regs [REG_FILE_SIZE];

  logic unused_awaddr_bits;
  assign unused_awaddr_bits = ^s_axi_lite_awaddr[1:0];

  assign s_axi_lite_awready = (wr_state == W_IDLE) || (wr_state == W_WAIT_ADDR);
  assign s_axi_lite_wready  = (wr_state == W_IDLE) || (wr_state == W_WAIT_DATA);

  for (genvar g = 0; g < REG_FILE_SIZE; g++) begin : g_reg_out
    assign reg_out[32*g +: 32] = regs[g];
  end

  // NOTE: the register array is a small bank of flops whose contents are
  // architecturally visible after reset, so it is reset like any other state;
  // a RAM-style array without reset would power up undefined.
  always_ff @(posedge s_axi_lite_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wr_state          <= W_IDLE;
      aw_idx            <= '0;
      w_data            <= '0;
      w_strb            <= '0;
      s_axi_lite_bvalid <= 1'b0;
      s_axi_lite_bresp  <= AXI_OK;
      reg_wr_pulse      <= '0;
      for (int i = 0; i < REG_FILE_SIZE; i++) regs[i] <= RESET_VALUE;
    end else begin
      reg_wr_pulse <= '0;
      case (wr_state)
        W_IDLE: begin
          if (s_axi_lite_awvalid && s_axi_lite_wvalid) begin
            aw_idx   <= s_axi_lite_awaddr[AXI_LITE_ADDR_WIDTH-1:2];
            w_data   <= s_axi_lite_wdata;
            w_strb   <= s_axi_lite_wstrb;
            wr_state <= W_COMMIT;
          end else if (s_axi_lite_awvalid) begin
            aw_idx   <= s_axi_lite_awaddr[AXI_LITE_ADDR_WIDTH-1:2];
            wr_state <= W_WAIT_DATA;
          end else if (s_axi_lite_wvalid) begin
            w_data   <= s_axi_lite_wdata;
            w_strb   <= s_axi_lite_wstrb;
            wr_state <= W_WAIT_ADDR;
          end
        end
        W_WAIT_DATA: begin
          if (s_axi_lite_wvalid) begin
            w_data   <= s_axi_lite_wdata;
            w_strb   <= s_axi_lite_wstrb;
            wr_state <= W_COMMIT;
          end
        end
        W_WAIT_ADDR: begin
          if (s_axi_lite_awvalid) begin
            aw_idx   <= s_axi_lite_awaddr[AXI_LITE_ADDR_WIDTH-1:2];
            wr_state <= W_COMMIT;
          end
        end
        W_COMMIT: begin
          // Status and unmapped indices fall through as SLVERR, no side effect.
          s_axi_lite_bresp <= AXI_SLVERR;
          for (int i = 0; i < REG_FILE_SIZE; i++) begin
            if (aw_idx == IDX_W'(i)) begin
              s_axi_lite_bresp <= AXI_OK;
              reg_wr_pulse[i]  <= 1'b1;
              for (int k = 0; k < 4; k++) begin
                if (w_strb[k]) regs[i][8*k +: 8] <= w_data[8*k +: 8];
              end
            end
          end
          s_axi_lite_bvalid <= 1'b1;
          wr_state          <= W_RESP;
        end
        W_RESP: begin
          if (s_axi_lite_bready) begin
            s_axi_lite_bvalid <= 1'b0;
            wr_state          <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  axi_lite_regfile_read_port #(
    .AXI_LITE_ADDR_WIDTH(AXI_LITE_ADDR_WIDTH),
    .REG_FILE_SIZE      (REG_FILE_SIZE),
    .NUM_STATUS         (NUM_STATUS)
  ) u_read_port (
    .s_axi_lite_aclk   (s_axi_lite_aclk),
    .axi_resetn        (axi_resetn),
    .s_axi_lite_araddr (s_axi_lite_araddr),
    .s_axi_lite_arvalid(s_axi_lite_arvalid),
    .s_axi_lite_arready(s_axi_lite_arready),
    .s_axi_lite_rdata  (s_axi_lite_rdata),
    .s_axi_lite_rresp  (s_axi_lite_rresp),
    .s_axi_lite_rvalid (s_axi_lite_rvalid),
    .s_axi_lite_rready (s_axi_lite_rready),
    .reg_flat          (reg_out),
    .status_in         (status_in)
  );

endmodule
